// File: rtl/mem_alloc_if.sv
// Request/response bundle between mem_alloc and its clients: the ICache miss port,
// the load/store buffer, and the byte-wide RAM/IO port.
interface mem_alloc_if #(
  parameter int ADDR_W = 32
);
  logic              if_to_alloc_en_in;
  logic [ADDR_W-1:0] if_a_in;
  logic [1:0]        if_offset_in;
  logic              alloc_to_if_gr_out;
  logic              alloc_to_if_en_out;
  logic [31:0]       if_d_out;

  logic              lsb_to_alloc_en_in;
  logic              lsb_wr_in;
  logic [ADDR_W-1:0] lsb_a_in;
  logic [1:0]        lsb_offset_in;
  logic [31:0]       lsb_d_in;
  logic              alloc_to_lsb_gr_out;
  logic              alloc_to_lsb_en_out;
  logic [31:0]       lsb_d_out;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  if_to_alloc_en_in, if_a_in, if_offset_in,
    output alloc_to_if_gr_out, alloc_to_if_en_out, if_d_out,
    input  lsb_to_alloc_en_in, lsb_wr_in, lsb_a_in, lsb_offset_in, lsb_d_in,
    output alloc_to_lsb_gr_out, alloc_to_lsb_en_out, lsb_d_out,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_to_alloc_en_in, if_a_in, if_offset_in,
    input  alloc_to_if_gr_out, alloc_to_if_en_out, if_d_out,
    output lsb_to_alloc_en_in, lsb_wr_in, lsb_a_in, lsb_offset_in, lsb_d_in,
    input  alloc_to_lsb_gr_out, alloc_to_lsb_en_out, lsb_d_out,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_alloc.sv
// Byte-serial RAM arbiter: LSB beats IF, 1-4 byte little-endian reads/writes.
// Optional CONFIG_IO_BUFFER_FULL_EN holds off UART writes while the IO FIFO is full.
module mem_alloc #(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_ADDR = 32'h30000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       clear_branch_in,
  mem_alloc_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]        state;
  logic              own_lsb;
  logic [ADDR_W-1:0] base;
  logic [1:0]        last;
  logic [31:0]       wdata, rdata, rdata_nxt;
  logic [2:0]        ki;        // next byte index to put on mem_a
  logic              pend;      // mem_din carries byte pend_idx this cycle
  logic [1:0]        pend_idx;
  logic              if_gr, if_en, lsb_gr, lsb_en;
  logic [31:0]       if_d, lsb_d;
  logic [7:0]        wbyte;
  logic              io_block, lsb_ok, if_ok, issuing, rd_done;

`ifdef CONFIG_IO_BUFFER_FULL_EN
  assign io_block = bus.lsb_wr_in && bus.io_buffer_full &&
                    ((bus.lsb_a_in == ADDR_W'(IO_ADDR)) || (bus.lsb_a_in == ADDR_W'(IO_ADDR + 32'd4)));
`else
  logic unused_io_full;
  assign unused_io_full = bus.io_buffer_full;
  assign io_block       = 1'b0;
`endif

  assign lsb_ok  = bus.lsb_to_alloc_en_in && !io_block;
  assign if_ok   = bus.if_to_alloc_en_in && !clear_branch_in;
  assign issuing = (state == S_READ) && (ki <= {1'b0, last});
  assign rd_done = pend && (pend_idx == last);

  always_comb begin
    rdata_nxt = rdata;
    rdata_nxt[{pend_idx, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    case (ki[1:0])
      2'd0:    wbyte = wdata[7:0];
      2'd1:    wbyte = wdata[15:8];
      2'd2:    wbyte = wdata[23:16];
      default: wbyte = wdata[31:24];
    endcase
  end

  // Address bus idles at 0 so no stray reads hit IO space between transfers.
  assign bus.mem_a    = (issuing || state == S_WRITE) ? base + ADDR_W'(ki) : '0;
  assign bus.mem_wr   = (state == S_WRITE) && rdy_in;
  assign bus.mem_dout = (state == S_WRITE) ? wbyte : 8'h00;

  assign bus.alloc_to_if_gr_out  = if_gr;
  assign bus.alloc_to_if_en_out  = if_en;
  assign bus.if_d_out            = if_d;
  assign bus.alloc_to_lsb_gr_out = lsb_gr;
  assign bus.alloc_to_lsb_en_out = lsb_en;
  assign bus.lsb_d_out           = lsb_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      own_lsb  <= 1'b0;
      base     <= '0;
      last     <= 2'd0;
      wdata    <= '0;
      rdata    <= '0;
      ki       <= 3'd0;
      pend     <= 1'b0;
      pend_idx <= 2'd0;
      if_gr    <= 1'b0;
      if_en    <= 1'b0;
      lsb_gr   <= 1'b0;
      lsb_en   <= 1'b0;
      if_d     <= '0;
      lsb_d    <= '0;
    end else begin
      if_gr  <= 1'b0;
      if_en  <= 1'b0;
      lsb_gr <= 1'b0;
      lsb_en <= 1'b0;
      if (!rdy_in) begin
        // RAM keeps answering the held address, so the in-flight byte is lost: re-issue it.
        if (state == S_READ && pend) begin
          ki   <= {1'b0, pend_idx};
          pend <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            ki    <= 3'd0;
            pend  <= 1'b0;
            rdata <= '0;
            if (lsb_ok) begin
              own_lsb <= 1'b1;
              base    <= bus.lsb_a_in;
              last    <= bus.lsb_offset_in;
              wdata   <= bus.lsb_d_in;
              lsb_gr  <= 1'b1;
              state   <= bus.lsb_wr_in ? S_WRITE : S_READ;
            end else if (if_ok) begin
              own_lsb <= 1'b0;
              base    <= bus.if_a_in;
              last    <= bus.if_offset_in;
              if_gr   <= 1'b1;
              state   <= S_READ;
            end
          end
          S_READ: begin
            if (!own_lsb && clear_branch_in) begin
              state <= S_IDLE;
              pend  <= 1'b0;
            end else begin
              if (issuing) begin
                pend     <= 1'b1;
                pend_idx <= ki[1:0];
                ki       <= ki + 3'd1;
              end else begin
                pend <= 1'b0;
              end
              if (pend) rdata <= rdata_nxt;
              if (rd_done) begin
                state <= S_IDLE;
                if (own_lsb) begin
                  lsb_d  <= rdata_nxt;
                  lsb_en <= 1'b1;
                end else begin
                  if_d  <= rdata_nxt;
                  if_en <= 1'b1;
                end
              end
            end
          end
          S_WRITE: begin
            if (ki[1:0] == last) begin
              state  <= S_IDLE;
              lsb_en <= 1'b1;
            end else begin
              ki <= ki + 3'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
